fft_frame_loader: RTL and testbench



---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_sample_bank.sv | 35 +++
 rtl/fft_frame_loader.sv | 168 ++++++++++++++++
 tb/tb_fft_frame_loader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point FFT datapath.
// Used by the frame loader and the core.
package fft_pkg;

  localparam int DW       = 32;
  localparam int N_POINTS = 8;
  localparam int IDX_W    = 3;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // IEEE-754 single 1.0, also the W^0 twiddle in the core
  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

endpackage

// File: rtl/fft_sample_bank.sv
// Eight complex sample registers, one written per cycle.
// All slots are exposed in parallel to the core.
module fft_sample_bank
  import fft_pkg::*;
#(
  parameter int W = DW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [W-1:0]            wr_real,
  input  logic [W-1:0]            wr_imag,
  output logic [N_POINTS*W-1:0]   rd_real,
  output logic [N_POINTS*W-1:0]   rd_imag
);

  logic [N_POINTS-1:0][W-1:0] re_q;
  logic [N_POINTS-1:0][W-1:0] im_q;

  // write the addressed slot; others hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q <= '0;
      im_q <= '0;
    end else if (we) begin
      re_q[widx] <= wr_real;
      im_q[widx] <= wr_imag;
    end
  end

  assign rd_real = re_q;
  assign rd_imag = im_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-parallel frame loader for the 8-point FFT core.
// Fills 8 samples, strobes start, holds until done or timeout.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  input  logic          in_mode,
  output logic          fft_str_sig,
  output logic          fft_switch,
  output logic [DW-1:0] fft_real_x0,
  output logic [DW-1:0] fft_real_x1,
  output logic [DW-1:0] fft_real_x2,
  output logic [DW-1:0] fft_real_x3,
  output logic [DW-1:0] fft_real_x4,
  output logic [DW-1:0] fft_real_x5,
  output logic [DW-1:0] fft_real_x6,
  output logic [DW-1:0] fft_real_x7,
  output logic [DW-1:0] fft_imag_x0,
  output logic [DW-1:0] fft_imag_x1,
  output logic [DW-1:0] fft_imag_x2,
  output logic [DW-1:0] fft_imag_x3,
  output logic [DW-1:0] fft_imag_x4,
  output logic [DW-1:0] fft_imag_x5,
  output logic [DW-1:0] fft_imag_x6,
  output logic [DW-1:0] fft_imag_x7,
  input  logic          fft_done_sig,
  input  logic          fft_error,
  output logic          busy,
  output logic          frame_err,
  output logic          timeout_err,
  input  logic          err_clr,
  output logic [15:0]   frame_cnt
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic              mode_pend_q;
  logic              sw_q;
  logic [7:0]        wait_q;
  logic              ferr_q, terr_q;
  logic [15:0]       cnt_q;

  logic              accept, last;
  logic              done_ok, tmo_hit;
  logic              ferr_set;

  logic [N_POINTS*DW-1:0] rd_real, rd_imag;

  assign in_ready = rst_n & (state_q == FILL);
  assign accept   = in_valid & in_ready;
  assign last     = accept & (idx_q == IDX_W'(N_POINTS - 1));
  assign ferr_set = (state_q == WAIT) & fft_error;

  // next state and per-state strobes
  always_comb begin
    state_d     = state_q;
    fft_str_sig = 1'b0;
    busy        = 1'b0;
    done_ok     = 1'b0;
    tmo_hit     = 1'b0;
    unique case (state_q)
      FILL: begin
        if (last) state_d = START;
      end
      START: begin
        fft_str_sig = 1'b1;
        busy        = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (fft_done_sig) begin
          done_ok = 1'b1;
          state_d = FILL;
        end else if (wait_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // write index, pending mode and held mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      mode_pend_q <= 1'b0;
      sw_q        <= 1'b1;
    end else if (accept) begin
      idx_q <= idx_q + 1'b1;
      if (idx_q == '0) mode_pend_q <= in_mode;
      if (last)        sw_q        <= mode_pend_q;
    end
  end

  // wait-cycle counter, cleared on start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wait_q <= '0;
    else if (state_q == START) wait_q <= '0;
    else if (state_q == WAIT)  wait_q <= wait_q + 8'd1;
  end

  // sticky flags (set beats clear) and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ferr_q <= 1'b0;
      terr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ferr_q <= ferr_set | (ferr_q & ~err_clr);
      terr_q <= tmo_hit  | (terr_q & ~err_clr);
      if (done_ok) cnt_q <= cnt_q + 16'd1;
    end
  end

  fft_sample_bank #(
    .W (DW)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept),
    .widx    (idx_q),
    .wr_real (in_real),
    .wr_imag (in_imag),
    .rd_real (rd_real),
    .rd_imag (rd_imag)
  );

  assign fft_switch  = sw_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;
  assign frame_cnt   = cnt_q;

  assign fft_real_x0 = rd_real[0*DW +: DW];
  assign fft_real_x1 = rd_real[1*DW +: DW];
  assign fft_real_x2 = rd_real[2*DW +: DW];
  assign fft_real_x3 = rd_real[3*DW +: DW];
  assign fft_real_x4 = rd_real[4*DW +: DW];
  assign fft_real_x5 = rd_real[5*DW +: DW];
  assign fft_real_x6 = rd_real[6*DW +: DW];
  assign fft_real_x7 = rd_real[7*DW +: DW];
  assign fft_imag_x0 = rd_imag[0*DW +: DW];
  assign fft_imag_x1 = rd_imag[1*DW +: DW];
  assign fft_imag_x2 = rd_imag[2*DW +: DW];
  assign fft_imag_x3 = rd_imag[3*DW +: DW];
  assign fft_imag_x4 = rd_imag[4*DW +: DW];
  assign fft_imag_x5 = rd_imag[5*DW +: DW];
  assign fft_imag_x6 = rd_imag[6*DW +: DW];
  assign fft_imag_x7 = rd_imag[7*DW +: DW];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: frame-level model plus directed
// scenarios and a randomized phase.
module tb_fft_frame_loader;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic [31:0] in_real = '0;
  logic [31:0] in_imag = '0;
  logic        fft_done_sig = 1'b0;
  logic        fft_error = 1'b0;
  logic        err_clr = 1'b0;

  logic        in_ready, fft_str_sig, fft_switch;
  logic        busy, frame_err, timeout_err;
  logic [15:0] frame_cnt;
  logic [31:0] rx0, rx1, rx2, rx3, rx4, rx5, rx6, rx7;
  logic [31:0] ix0, ix1, ix2, ix3, ix4, ix5, ix6, ix7;
  logic [31:0] ore [8];
  logic [31:0] oim [8];

  assign ore[0] = rx0; assign ore[1] = rx1;
  assign ore[2] = rx2; assign ore[3] = rx3;
  assign ore[4] = rx4; assign ore[5] = rx5;
  assign ore[6] = rx6; assign ore[7] = rx7;
  assign oim[0] = ix0; assign oim[1] = ix1;
  assign oim[2] = ix2; assign oim[3] = ix3;
  assign oim[4] = ix4; assign oim[5] = ix5;
  assign oim[6] = ix6; assign oim[7] = ix7;

  fft_frame_loader #(
    .DW      (32),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_real      (in_real),
    .in_imag      (in_imag),
    .in_mode      (in_mode),
    .fft_str_sig  (fft_str_sig),
    .fft_switch   (fft_switch),
    .fft_real_x0  (rx0),
    .fft_real_x1  (rx1),
    .fft_real_x2  (rx2),
    .fft_real_x3  (rx3),
    .fft_real_x4  (rx4),
    .fft_real_x5  (rx5),
    .fft_real_x6  (rx6),
    .fft_real_x7  (rx7),
    .fft_imag_x0  (ix0),
    .fft_imag_x1  (ix1),
    .fft_imag_x2  (ix2),
    .fft_imag_x3  (ix3),
    .fft_imag_x4  (ix4),
    .fft_imag_x5  (ix5),
    .fft_imag_x6  (ix6),
    .fft_imag_x7  (ix7),
    .fft_done_sig (fft_done_sig),
    .fft_error    (fft_error),
    .busy         (busy),
    .frame_err    (frame_err),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int str_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // behavioural model: frame-level bookkeeping
  int          m_cnt = 0;
  bit          m_start = 0;
  int          m_wait = -1;
  bit          m_sw = 1;
  bit          m_pm = 0;
  bit          m_ferr = 0;
  bit          m_terr = 0;
  logic [15:0] m_frames = '0;
  logic [31:0] m_re [8];
  logic [31:0] m_im [8];

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_re[i] = '0;
      m_im[i] = '0;
    end
  end

  always @(posedge clk) begin : model
    bit fe, te, pm;
    if (!rst_n) begin
      m_cnt <= 0; m_start <= 0; m_wait <= -1;
      m_sw <= 1; m_pm <= 0;
      m_ferr <= 0; m_terr <= 0; m_frames <= '0;
      for (int i = 0; i < 8; i++) begin
        m_re[i] <= '0;
        m_im[i] <= '0;
      end
    end else begin
      fe = 0;
      te = 0;
      if (m_start) begin
        m_start <= 0;
        m_wait <= 0;
      end else if (m_wait >= 0) begin
        fe = fft_error;
        if (fft_done_sig) begin
          m_frames <= m_frames + 16'd1;
          m_wait <= -1;
        end else if (m_wait + 1 >= TO) begin
          te = 1;
          m_wait <= -1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (in_valid) begin
        pm = (m_cnt == 0) ? in_mode : m_pm;
        m_pm <= pm;
        m_re[m_cnt] <= in_real;
        m_im[m_cnt] <= in_imag;
        if (m_cnt == 7) begin
          m_cnt <= 0;
          m_sw <= pm;
          m_start <= 1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
      m_ferr <= fe | (m_ferr & !err_clr);
      m_terr <= te | (m_terr & !err_clr);
    end
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin : compare
    bit eb;
    eb = m_start || (m_wait >= 0);
    chk("in_ready", in_ready, rst_n && !eb);
    chk("str_sig", fft_str_sig, m_start);
    chk("busy", busy, eb);
    chk("switch", fft_switch, m_sw);
    chk("frame_err", frame_err, m_ferr);
    chk("timeout_err", timeout_err, m_terr);
    chk("frame_cnt", frame_cnt, m_frames);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("real_x%0d", i), ore[i], m_re[i]);
      chk($sformatf("imag_x%0d", i), oim[i], m_im[i]);
    end
    if (fft_str_sig) str_seen++;
  end

  logic [31:0] fp_tab [8];
  logic [31:0] sent_re [8];
  logic [31:0] sent_im [8];

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // stream a frame (or a partial one up to stop_at samples)
  task automatic send_frame(input bit gap, input bit mode0,
                            input bit flip, input bit seq,
                            input int stop_at);
    int cyc;
    bit tog;
    cyc = 0;
    tog = 1;
    while (1) begin
      in_valid = gap ? tog : 1'b1;
      tog = !tog;
      in_mode = (flip && m_cnt >= 3) ? !mode0 : mode0;
      in_real = seq ? fp_tab[m_cnt] : $urandom;
      in_imag = seq ? 32'd0 : $urandom;
      if (in_valid) begin
        sent_re[m_cnt] = in_real;
        sent_im[m_cnt] = in_imag;
      end
      tick();
      if (m_start || (stop_at < 8 && m_cnt >= stop_at)) break;
      cyc++;
      if (cyc > 200) begin
        chk("send_bound", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input int delay, input bit err);
    repeat (delay - 1) tick();
    fft_done_sig = 1'b1;
    fft_error = err;
    tick();
    fft_done_sig = 1'b0;
    fft_error = 1'b0;
  endtask

  initial begin
    int s0;
    fp_tab[0] = 32'h3F80_0000; fp_tab[1] = 32'h4000_0000;
    fp_tab[2] = 32'h4040_0000; fp_tab[3] = 32'h4080_0000;
    fp_tab[4] = 32'h40A0_0000; fp_tab[5] = 32'h40C0_0000;
    fp_tab[6] = 32'h40E0_0000; fp_tab[7] = 32'h4100_0000;

    repeat (2) tick();
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_switch", fft_switch, 1'b1);
    chk("rst_cnt", frame_cnt, 16'd0);
    rst_n = 1'b1;
    tick();

    // basic FFT frame
    send_frame(0, 1, 0, 1, 8);
    chk("basic_start", fft_str_sig, 1'b1);
    chk("basic_x3", rx3, 32'h4080_0000);
    chk("model_x3", m_re[3], 32'h4080_0000);
    chk("basic_sw", fft_switch, 1'b1);
    finish_frame(10, 0);
    chk("basic_cnt", frame_cnt, 16'd1);
    chk("basic_ready", in_ready, 1'b1);

    // gapped input, mode flips mid-frame
    send_frame(1, 0, 1, 1, 8);
    chk("gap_sw", fft_switch, 1'b0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("gap_x%0d", i), ore[i], fp_tab[i]);
    finish_frame(3, 0);
    chk("gap_cnt", frame_cnt, 16'd2);

    // hold stability while new data is offered
    send_frame(0, 1, 0, 0, 8);
    for (int c = 0; c < 15; c++) begin
      in_valid = 1'b1;
      in_real = $urandom;
      in_imag = $urandom;
      tick();
      chk("hold_ready", in_ready, 1'b0);
      for (int i = 0; i < 8; i++) begin
        chk("hold_re", ore[i], sent_re[i]);
        chk("hold_im", oim[i], sent_im[i]);
      end
    end
    in_valid = 1'b0;
    finish_frame(1, 0);
    chk("hold_cnt", frame_cnt, 16'd3);

    // timeout: last WAIT cycle, then expiry
    send_frame(0, 1, 0, 1, 8);
    repeat (TO) tick();
    chk("tmo_busy_edge", busy, 1'b1);
    chk("tmo_err_edge", timeout_err, 1'b0);
    tick();
    chk("tmo_err", timeout_err, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_cnt", frame_cnt, 16'd3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_clr", timeout_err, 1'b0);

    // error and done in the same cycle
    send_frame(0, 0, 0, 0, 8);
    finish_frame(5, 1);
    chk("errdone_ferr", frame_err, 1'b1);
    chk("errdone_cnt", frame_cnt, 16'd4);
    chk("errdone_terr", timeout_err, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errdone_clr", frame_err, 1'b0);

    // reset mid-frame
    send_frame(0, 1, 0, 1, 5);
    rst_n = 1'b0;
    tick();
    chk("mrst_ready", in_ready, 1'b0);
    chk("mrst_x0", rx0, 32'd0);
    chk("mrst_sw", fft_switch, 1'b1);
    chk("mrst_cnt", frame_cnt, 16'd0);
    chk("mrst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    s0 = str_seen;
    send_frame(0, 0, 0, 0, 8);
    finish_frame(4, 0);
    chk("mrst_pulses", 32'(str_seen - s0), 32'd1);
    for (int i = 0; i < 8; i++)
      chk("mrst_slot", ore[i], sent_re[i]);
    chk("mrst_cnt1", frame_cnt, 16'd1);

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom % 4) != 0;
      in_real = $urandom;
      in_imag = $urandom;
      in_mode = $urandom % 2;
      fft_done_sig = ($urandom % 12) == 0;
      fft_error = ($urandom % 10) == 0;
      err_clr = ($urandom % 16) == 0;
      tick();
    end
    in_valid = 1'b0;
    fft_done_sig = 1'b0;
    fft_error = 1'b0;
    err_clr = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
